flag_branch_unit: RTL
=====================

# flag_branch_unit

Consumer end of the ALU zero-detect path. It registers the N/Z/V/C condition flags produced by the ALU, including the zero flag from the 64-input NOR zero detector, on flag-setting instructions. It resolves conditional and unconditional branches in the execute stage against those flags or a fresh register-zero detect. It then drives a registered branch-taken pulse and a multi-cycle squash window that kills the wrong-path instructions behind a taken branch.

## Interface
Parameters:
- `SQUASH_CYC`, default 2: number of consecutive cycles squash is held after a taken branch; legal range 1..3.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: reset, synchronous and active-high.
- `valid_in`  in  1: the instruction in execute is valid.
- `set_flags`  in  1: the instruction is flag-setting (ADDS/SUBS).
- `alu_neg`, `alu_zero`, `alu_ovf`, `alu_carry`  in  1 each: raw ALU flags for this cycle; `alu_zero` comes from the 64-bit NOR zero detector.
- `br_type`  in  2: 00 none, 01 B (unconditional), 10 CBZ, 11 B.LT.
- `rt_zero`  in  1: zero-detect of the CBZ source register.
- `flags_q`  out  4: stored flags {N,Z,V,C}.
- `br_taken`  out  1: registered one-cycle taken pulse.
- `squash`  out  1: kill the execute-stage instruction this cycle.

## Operation
- Qualified instruction: `qual = valid_in & ~squash`. An unqualified cycle updates nothing and evaluates nothing.
- Flag register: on `qual & set_flags`, `flags_q <= {alu_neg, alu_zero, alu_ovf, alu_carry}`. Otherwise it holds.
- Condition evaluation is combinational, in `br_cond`:
  - B: taken = 1.
  - CBZ: taken = `rt_zero`.
  - B.LT: taken = `flags_q[N] ^ flags_q[V]`.
  - none: taken = 0.
- A B.LT that is also flag-setting is never issued by the decoder. If it occurs, the branch uses the pre-update `flags_q` and the flags still update.
- FSM states:
  - IDLE:
    - `qual & taken` → SQUASH, load counter with SQUASH_CYC-1.
    - Otherwise stay in IDLE.
  - SQUASH:
    - `squash=1`.
    - Counter > 0: decrement and stay in SQUASH.
    - Counter == 0: → IDLE.
    - Incoming branches and `set_flags` are ignored.
- Counter width is 2 bits; it cannot wrap, because it is never decremented at 0.

## Timing
- Reset values: `flags_q=4'b0000`, `br_taken=0`, `squash=0`, state IDLE, counter 0.
- Evaluation and taken timing:
  - Taken branch evaluated at edge k.
  - `br_taken=1` during cycle k+1 only.
  - `squash=1` during cycles k+1 .. k+SQUASH_CYC.
- `flags_q` reflects a flag-setting instruction from the edge after its cycle. A B.LT in the very next cycle sees the new flags; no bypass is required.
- A taken branch on the first cycle after squash drops is accepted normally; this is a back-to-back window.
- Reset asserted in any state forces all reset values at that edge, including mid-squash. `br_taken` never survives reset.
- Reset overrides a same-cycle `set_flags`.

## Structure
- Package `branch_pkg`:
  - `br_type_t` enum (BR_NONE, BR_B, BR_CBZ, BR_BLT).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0.
  - FSM state enum (ST_IDLE, ST_SQUASH).
- Sub-module `br_cond`: purely combinational taken evaluation from `br_type`, `rt_zero`, `flags_q`; separately testable.
- Top-level contents: flag register, FSM, squash counter, `br_taken` register.

## Test plan
- Reset release:
  - Stimulus: hold `reset` 2 cycles with `set_flags=1`, `alu_zero=1`.
  - Required: `flags_q=0000`, `br_taken=0`, `squash=0` throughout.
- Flag capture then B.LT:
  - Stimulus: SUBS with N=1, V=0 at cycle 0; B.LT at cycle 1.
  - Required: `flags_q=1000` from cycle 1; `br_taken=1` at cycle 2 only; `squash=1` at cycles 2-3 (SQUASH_CYC=2).
- CBZ both polarities:
  - Stimulus: CBZ with `rt_zero=0`, then CBZ with `rt_zero=1`.
  - Required: not taken (no pulse, no squash) for the first; taken for the second.
- Squash window:
  - Stimulus: B at cycle 0; then B and SUBS with all flags 1 during cycles 1-2.
  - Required: only one `br_taken` pulse; `flags_q` unchanged.
- Back-to-back:
  - Stimulus: B at cycle 0; B again at cycle 3 (first non-squashed cycle).
  - Required: `br_taken` at cycles 1 and 4; `squash` at cycles 1-2 and 4-5.
- Reset mid-squash:
  - Stimulus: taken B at cycle 0; `reset` at cycle 1.
  - Required: `squash=0`, state IDLE from cycle 2; a B at cycle 2 is taken.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the execute-stage flag register and branch resolver.
package branch_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_B    = 2'b01,
        BR_CBZ  = 2'b10,
        BR_BLT  = 2'b11
    } br_type_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

endpackage

// File: rtl/br_cond.sv
// Combinational branch-condition evaluation against stored flags or the CBZ zero detect.
module br_cond
    import branch_pkg::*;
(
    input  br_type_t   br_type_i,
    input  logic       rt_zero_i,
    input  logic [3:0] flags_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        unique case (br_type_i)
            BR_NONE: taken_o = 1'b0;
            BR_B:    taken_o = 1'b1;
            BR_CBZ:  taken_o = rt_zero_i;
            BR_BLT:  taken_o = flags_i[FLAG_N] ^ flags_i[FLAG_V];
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register, branch resolution and post-branch squash window for the execute stage.
module flag_branch_unit
    import branch_pkg::*;
#(
    parameter int SQUASH_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic       set_flags,
    input  logic       alu_neg,
    input  logic       alu_zero,
    input  logic       alu_ovf,
    input  logic       alu_carry,
    input  logic [1:0] br_type,
    input  logic       rt_zero,
    output logic [3:0] flags_q,
    output logic       br_taken,
    output logic       squash
);

    state_t     state_q;
    logic [1:0] cnt_q;
    logic       br_taken_q;
    logic       squash_q;
    logic       qual;
    logic       taken;
    logic [3:0] flags_d;

    assign qual    = valid_in & ~squash_q;
    assign flags_d = {alu_neg, alu_zero, alu_ovf, alu_carry};

    br_cond u_br_cond (
        .br_type_i (br_type_t'(br_type)),
        .rt_zero_i (rt_zero),
        .flags_i   (flags_q),
        .taken_o   (taken)
    );

    // Squash is held from the registered state, so qual blocks flag updates
    // and new branches for the whole window without extra gating.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            br_taken_q <= 1'b0;
            squash_q   <= 1'b0;
            flags_q    <= 4'b0000;
        end else begin
            br_taken_q <= 1'b0;
            if (qual && set_flags) begin
                flags_q <= flags_d;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (qual && taken) begin
                        state_q    <= ST_SQUASH;
                        cnt_q      <= 2'(SQUASH_CYC - 1);
                        br_taken_q <= 1'b1;
                        squash_q   <= 1'b1;
                    end
                end
                ST_SQUASH: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        state_q  <= ST_IDLE;
                        squash_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    squash_q <= 1'b0;
                end
            endcase
        end
    end

    assign br_taken = br_taken_q;
    assign squash   = squash_q;

endmodule
